// File: rtl/btb_update_ctrl.sv
// Resolve-stage branch checker: redirects/flushes on mispredict and queues BTB/BHT
// training updates in a small FIFO that drains whenever the BTB is not stalled.
module btb_update_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic        res_taken,
  input  logic [15:0] res_target,
  input  logic        pred_hit,
  input  logic        pred_taken,
  input  logic [15:0] pred_target,
  input  logic        btb_stall,
  output logic        res_ready,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic        upd_valid,
  output logic [15:0] upd_pc,
  output logic [15:0] upd_target,
  output logic        upd_taken,
  output logic        upd_alloc,
  output logic [15:0] mispredict_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] target;
    logic        taken;
    logic        alloc;
  } upd_t;

  state_e          state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  upd_t            mem_q [DEPTH];
  upd_t            head_ent;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            redirect_q, redirect_d;
  logic [15:0]     redirect_pc_q, redirect_pc_d;
  logic [15:0]     mis_cnt_q, mis_cnt_d;

  logic idle, fifo_full, fifo_empty, acc, mis, push, pop, mis_event;

  assign idle       = (state_q == S_IDLE);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // During a flush everything is wrong-path, so it is swallowed even if the FIFO is full.
  assign res_ready = reset_n && (idle ? !fifo_full : 1'b1);
  assign acc       = res_valid && res_ready;
  assign mis       = (pred_taken != res_taken) || (res_taken && (pred_target != res_target));
  assign mis_event = idle && acc && mis;
  // A not-taken branch that missed the BTB has nothing worth training.
  assign push      = idle && acc && (pred_hit || res_taken);
  assign pop       = !fifo_empty && !btb_stall;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (mis_event) begin
          state_d = S_FLUSH;
          fcnt_d  = FCW'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    redirect_d    = mis_event;
    redirect_pc_d = redirect_pc_q;
    mis_cnt_d     = mis_cnt_q;
    if (mis_event) begin
      redirect_pc_d = res_taken ? res_target : (res_pc + 16'd2);
      if (mis_cnt_q != 16'hFFFF) begin
        mis_cnt_d = mis_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      fcnt_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  // Storage is not reset; resetting the pointers is enough to discard pending updates.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: res_pc, target: res_target, taken: res_taken, alloc: !pred_hit};
    end
  end

  assign head_ent = mem_q[rd_ptr_q];

  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = (state_q == S_FLUSH);
  assign upd_valid      = !fifo_empty;
  assign upd_pc         = fifo_empty ? 16'h0000 : head_ent.pc;
  assign upd_target     = fifo_empty ? 16'h0000 : head_ent.target;
  assign upd_taken      = fifo_empty ? 1'b0 : head_ent.taken;
  assign upd_alloc      = fifo_empty ? 1'b0 : head_ent.alloc;
  assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: redirect/flush timing, update FIFO order,
// stall backpressure, counter saturation and reset during flush.
module tb_btb_update_ctrl;

  logic        clk;
  logic        reset_n;
  logic        res_valid;
  logic [15:0] res_pc;
  logic        res_taken;
  logic [15:0] res_target;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        btb_stall;
  logic        res_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        upd_alloc;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  btb_update_ctrl #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .btb_stall      (btb_stall),
    .res_ready      (res_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .upd_alloc      (upd_alloc),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic tk,
                       input logic [15:0] tg, input logic h, input logic pt,
                       input logic [15:0] ptg);
    res_valid   = v;
    res_pc      = pc;
    res_taken   = tk;
    res_target  = tg;
    pred_hit    = h;
    pred_taken  = pt;
    pred_target = ptg;
    $display("txn t=%0t valid=%b pc=%h taken=%b target=%h hit=%b ptaken=%b ptarget=%h stall=%b",
             $time, v, pc, tk, tg, h, pt, ptg, btb_stall);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".res_ready"},   32'(res_ready),      32'h0);
    chk({tag, ".redirect"},    32'(redirect),       32'h0);
    chk({tag, ".redirect_pc"}, 32'(redirect_pc),    32'h0);
    chk({tag, ".flush"},       32'(flush),          32'h0);
    chk({tag, ".upd_valid"},   32'(upd_valid),      32'h0);
    chk({tag, ".upd_pc"},      32'(upd_pc),         32'h0);
    chk({tag, ".upd_target"},  32'(upd_target),     32'h0);
    chk({tag, ".upd_taken"},   32'(upd_taken),      32'h0);
    chk({tag, ".upd_alloc"},   32'(upd_alloc),      32'h0);
    chk({tag, ".mis_cnt"},     32'(mispredict_cnt), 32'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    btb_stall = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // Reset state
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    reset_n = 1'b1;
    #1 chk("post_reset.res_ready", 32'(res_ready), 32'h1);

    // 1. Correct prediction 0x3000 -> 0x3040
    @(negedge clk);
    drive(1'b1, 16'h3000, 1'b1, 16'h3040, 1'b1, 1'b1, 16'h3040);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    chk("t1.redirect",   32'(redirect),   32'h0);
    chk("t1.flush",      32'(flush),      32'h0);
    chk("t1.upd_valid",  32'(upd_valid),  32'h1);
    chk("t1.upd_pc",     32'(upd_pc),     32'h3000);
    chk("t1.upd_target", 32'(upd_target), 32'h3040);
    chk("t1.upd_taken",  32'(upd_taken),  32'h1);
    chk("t1.upd_alloc",  32'(upd_alloc),  32'h0);
    @(negedge clk);
    #1 chk("t1.popped", 32'(upd_valid), 32'h0);

    // 2. Taken branch that missed the BTB
    @(negedge clk);
    drive(1'b1, 16'h2000, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    chk("t2.redirect",    32'(redirect),       32'h1);
    chk("t2.redirect_pc", 32'(redirect_pc),    32'h1234);
    chk("t2.flush0",      32'(flush),          32'h1);
    chk("t2.res_ready",   32'(res_ready),      32'h1);
    chk("t2.upd_valid",   32'(upd_valid),      32'h1);
    chk("t2.upd_pc",      32'(upd_pc),         32'h2000);
    chk("t2.upd_target",  32'(upd_target),     32'h1234);
    chk("t2.upd_alloc",   32'(upd_alloc),      32'h1);
    chk("t2.mis_cnt",     32'(mispredict_cnt), 32'h1);
    @(negedge clk);
    #1;
    chk("t2.redirect_off", 32'(redirect),  32'h0);
    chk("t2.flush1",       32'(flush),     32'h1);
    chk("t2.popped",       32'(upd_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("t2.flush_end", 32'(flush),     32'h0);
    chk("t2.ready",     32'(res_ready), 32'h1);

    // 3. Predicted taken, actually not taken at 0xFFFE; wrong-path inputs during flush
    @(negedge clk);
    drive(1'b1, 16'hFFFE, 1'b0, 16'h5555, 1'b1, 1'b1, 16'h4000);
    @(negedge clk);
    drive(1'b1, 16'h6000, 1'b1, 16'h6100, 1'b1, 1'b0, 16'h6000);
    #1;
    chk("t3.redirect",    32'(redirect),       32'h1);
    chk("t3.redirect_pc", 32'(redirect_pc),    32'h0000);
    chk("t3.flush0",      32'(flush),          32'h1);
    chk("t3.res_ready",   32'(res_ready),      32'h1);
    chk("t3.mis_cnt",     32'(mispredict_cnt), 32'h2);
    chk("t3.upd_valid",   32'(upd_valid),      32'h1);
    chk("t3.upd_pc",      32'(upd_pc),         32'hFFFE);
    chk("t3.upd_taken",   32'(upd_taken),      32'h0);
    chk("t3.upd_alloc",   32'(upd_alloc),      32'h0);
    @(negedge clk);
    #1;
    chk("t3.flush1",       32'(flush),     32'h1);
    chk("t3.redirect_off", 32'(redirect),  32'h0);
    chk("t3.ready_flush",  32'(res_ready), 32'h1);
    chk("t3.no_enqueue",   32'(upd_valid), 32'h0);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    chk("t3.flush_end",   32'(flush),          32'h0);
    chk("t3.no_redirect", 32'(redirect),       32'h0);
    chk("t3.dropped",     32'(upd_valid),      32'h0);
    chk("t3.mis_hold",    32'(mispredict_cnt), 32'h2);

    // 4. Stall with five hits offered; FIFO fills at four
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btb_stall = 1'b1;
      drive(1'b1, 16'(32'h0100 + i * 16), 1'b1, 16'(32'h1100 + i * 16), 1'b1, 1'b1,
            16'(32'h1100 + i * 16));
      #1 chk($sformatf("t4.ready%0d", i), 32'(res_ready), (i < 4) ? 32'h1 : 32'h0);
      if (i > 0) begin
        chk($sformatf("t4.stable_pc%0d", i), 32'(upd_pc), 32'h0100);
      end
    end
    @(negedge clk);
    #1;
    chk("t4.stall_pc",     32'(upd_pc),     32'h0100);
    chk("t4.stall_target", 32'(upd_target), 32'h1100);
    chk("t4.stall_ready",  32'(res_ready),  32'h0);
    @(negedge clk);
    btb_stall = 1'b0;
    #1;
    chk("t4.full_ready", 32'(res_ready), 32'h0);
    chk("t4.head0",      32'(upd_pc),    32'h0100);
    @(negedge clk);
    #1;
    chk("t4.ready_rise", 32'(res_ready), 32'h1);
    chk("t4.head1",      32'(upd_pc),    32'h0110);
    @(negedge clk);
    res_valid = 1'b0;
    #1 chk("t4.head2", 32'(upd_pc), 32'h0120);
    for (int k = 3; k < 5; k++) begin
      @(negedge clk);
      #1 chk($sformatf("t4.head%0d", k), 32'(upd_pc), 32'(32'h0100 + k * 16));
    end
    @(negedge clk);
    #1 chk("t4.drained", 32'(upd_valid), 32'h0);

    // 5a. Push and pop together at count 2
    @(negedge clk);
    btb_stall = 1'b1;
    drive(1'b1, 16'h0200, 1'b1, 16'h2200, 1'b1, 1'b1, 16'h2200);
    @(negedge clk);
    drive(1'b1, 16'h0210, 1'b1, 16'h2210, 1'b1, 1'b1, 16'h2210);
    @(negedge clk);
    btb_stall = 1'b0;
    drive(1'b1, 16'h0220, 1'b1, 16'h2220, 1'b1, 1'b1, 16'h2220);
    #1 chk("t5.head_a", 32'(upd_pc), 32'h0200);
    @(negedge clk);
    res_valid = 1'b0;
    btb_stall = 1'b1;
    #1 chk("t5.head_b", 32'(upd_pc), 32'h0210);
    @(negedge clk);
    btb_stall = 1'b0;
    #1 chk("t5.head_b_held", 32'(upd_pc), 32'h0210);
    @(negedge clk);
    #1 chk("t5.head_c", 32'(upd_pc), 32'h0220);
    @(negedge clk);
    #1 chk("t5.count_two", 32'(upd_valid), 32'h0);

    // 5b. Saturating mispredict counter
    @(negedge clk);
    force dut.mis_cnt_q = 16'hFFFF;
    #1 chk("t5.forced", 32'(mispredict_cnt), 32'hFFFF);
    @(negedge clk);
    release dut.mis_cnt_q;
    drive(1'b1, 16'h0300, 1'b0, 16'h3300, 1'b1, 1'b1, 16'h3400);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    chk("t5.redirect",    32'(redirect),       32'h1);
    chk("t5.redirect_pc", 32'(redirect_pc),    32'h0302);
    chk("t5.saturated",   32'(mispredict_cnt), 32'hFFFF);
    repeat (2) @(negedge clk);
    #1;
    chk("t5.flush_end", 32'(flush),     32'h0);
    chk("t5.drained",   32'(upd_valid), 32'h0);

    // 6. Reset during flush with three queued updates
    @(negedge clk);
    btb_stall = 1'b1;
    drive(1'b1, 16'h0400, 1'b1, 16'h4400, 1'b1, 1'b1, 16'h4400);
    @(negedge clk);
    drive(1'b1, 16'h0410, 1'b1, 16'h4410, 1'b1, 1'b1, 16'h4410);
    @(negedge clk);
    drive(1'b1, 16'h0420, 1'b0, 16'h4420, 1'b1, 1'b1, 16'h5000);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    chk("t6.in_flush", 32'(flush),     32'h1);
    chk("t6.queued",   32'(upd_valid), 32'h1);
    chk("t6.head",     32'(upd_pc),    32'h0400);
    reset_n = 1'b0;
    #1 chk_all_zero("t6.reset");
    @(negedge clk);
    btb_stall = 1'b0;
    reset_n   = 1'b1;
    #1;
    chk("t6.ready", 32'(res_ready), 32'h1);
    chk("t6.idle",  32'(flush),     32'h0);
    chk("t6.empty", 32'(upd_valid), 32'h0);
    @(negedge clk);
    drive(1'b1, 16'h0500, 1'b1, 16'h5500, 1'b1, 1'b1, 16'h5500);
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    chk("t6.new_valid", 32'(upd_valid), 32'h1);
    chk("t6.new_pc",    32'(upd_pc),    32'h0500);
    chk("t6.no_flush",  32'(flush),     32'h0);
    @(negedge clk);
    #1 chk("t6.new_popped", 32'(upd_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
